// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage instruction info and pipeline results in,
// stall/flush control and forwarded operands out.
// master = datapath/decoder side, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32
) ();
    logic                         id_valid;
    logic [REG_AW-1:0]            id_rs1_addr;
    logic                         id_rs1_used;
    logic [REG_AW-1:0]            id_rs2_addr;
    logic                         id_rs2_used;
    logic [REG_AW-1:0]            id_rd_addr;
    logic                         id_rf_wen;
    logic                         id_is_load;
    logic                         ex_jump;
    logic [NUM_STAGES*XLEN-1:0]   stage_data;
    logic                         rs1_fwd_en;
    logic [XLEN-1:0]              rs1_fwd_data;
    logic                         rs2_fwd_en;
    logic [XLEN-1:0]              rs2_fwd_data;
    logic                         stall;
    logic                         flush;
    logic [CNT_W-1:0]             stall_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, ex_jump, stage_data,
        input  rs1_fwd_en, rs1_fwd_data, rs2_fwd_en, rs2_fwd_data,
               stall, flush, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, ex_jump, stage_data,
        output rs1_fwd_en, rs1_fwd_data, rs2_fwd_en, rs2_fwd_data,
               stall, flush, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the in-order core.
// A shift-register scoreboard tracks in-flight RF writes (entry 0 = EX).
// Define HAZARD_FWD_EN to enable operand forwarding; without it the block is
// a pure interlock that stalls on any matching in-flight write.
module hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 32
) (
    input logic              clk,
    input logic              reset,
    hazard_scoreboard_if.slave bus
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_MODE = 1'b1;
`else
    localparam bit FWD_MODE = 1'b0;
`endif

    logic [NUM_STAGES-1:0] ent_valid;
    logic [NUM_STAGES-1:0] ent_wen;
    logic [NUM_STAGES-1:0] ent_load;
    logic [REG_AW-1:0]     ent_rd [NUM_STAGES];

    logic [1:0]            src_used;
    logic [REG_AW-1:0]     src_addr [2];
    logic [1:0]            src_hit;
    logic [1:0]            src_ready;
    logic [XLEN-1:0]       src_data [2];

    logic                  hazard;
    logic                  stall;
    logic                  rs1_en;
    logic                  rs2_en;
    logic [CNT_W-1:0]      stall_cnt;

    assign src_used    = {bus.id_rs2_used, bus.id_rs1_used};
    assign src_addr[0] = bus.id_rs1_addr;
    assign src_addr[1] = bus.id_rs2_addr;

    // Youngest matching in-flight write per source (lowest entry index wins).
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            src_hit[s]   = 1'b0;
            src_ready[s] = 1'b0;
            src_data[s]  = '0;
            for (int unsigned k = 0; k < unsigned'(NUM_STAGES); k++) begin
                if (!src_hit[s] && src_used[s] && (src_addr[s] != '0) &&
                    ent_valid[k] && ent_wen[k] && (ent_rd[k] == src_addr[s])) begin
                    src_hit[s]   = 1'b1;
                    src_ready[s] = !ent_load[k] || (k >= unsigned'(LOAD_STAGE));
                    src_data[s]  = bus.stage_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Stall decision; a taken jump in EX squashes ID, so it never stalls.
    always_comb begin
        hazard = 1'b0;
        if (FWD_MODE) begin
            hazard = (src_hit[0] & ~src_ready[0]) | (src_hit[1] & ~src_ready[1]);
        end else begin
            hazard = |src_hit;
        end
        stall = hazard & ~bus.ex_jump;
    end

    assign rs1_en           = FWD_MODE & src_hit[0] & src_ready[0];
    assign rs2_en           = FWD_MODE & src_hit[1] & src_ready[1];
    assign bus.rs1_fwd_en   = rs1_en;
    assign bus.rs2_fwd_en   = rs2_en;
    assign bus.rs1_fwd_data = rs1_en ? src_data[0] : '0;
    assign bus.rs2_fwd_data = rs2_en ? src_data[1] : '0;
    assign bus.stall        = stall;
    assign bus.flush        = bus.ex_jump;
    assign bus.stall_cnt    = stall_cnt;

    // Scoreboard shift: ID enters entry 0 unless stalled or squashed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_wen   <= '0;
            ent_load  <= '0;
            for (int unsigned k = 0; k < unsigned'(NUM_STAGES); k++) begin
                ent_rd[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < unsigned'(NUM_STAGES); k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wen[k]   <= ent_wen[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            ent_valid[0] <= bus.id_valid & ~stall & ~bus.ex_jump;
            ent_wen[0]   <= bus.id_rf_wen;
            ent_load[0]  <= bus.id_is_load;
            ent_rd[0]    <= bus.id_rd_addr;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table, reset/saturation
// sequences, and randomized traffic against a queue-based reference model.
module tb_hazard_scoreboard;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int NUM_STAGES = 3;
    localparam int LOAD_STAGE = 1;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES),
                           .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES),
                        .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus shadow
    bit in_valid, in_u1, in_u2, in_wen, in_ld, in_jump;
    int in_rs1, in_rs2, in_rd;
    logic [31:0] sdata [NUM_STAGES];

    // reference model: queue of in-flight writes, index = age (0 = EX)
    typedef struct { bit valid; int rd; bit wen; bit ld; } rec_t;
    rec_t mq[$];
    int   mcnt;
    bit   m_stall;

    typedef struct {
        int valid, rs1, u1, rs2, u2, rd, wen, ld, jump;
        int e_stall, e_en1, e_d1, e_en2, e_d2, e_cnt;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.id_valid    = in_valid;
        bus.id_rs1_addr = in_rs1[REG_AW-1:0];
        bus.id_rs1_used = in_u1;
        bus.id_rs2_addr = in_rs2[REG_AW-1:0];
        bus.id_rs2_used = in_u2;
        bus.id_rd_addr  = in_rd[REG_AW-1:0];
        bus.id_rf_wen   = in_wen;
        bus.id_is_load  = in_ld;
        bus.ex_jump     = in_jump;
        bus.stage_data  = {sdata[2], sdata[1], sdata[0]};
    endtask

    task automatic set_instr(input bit v, input int r1, input bit u1, input int r2,
                             input bit u2, input int rd, input bit wen, input bit ld,
                             input bit jmp);
        in_valid = v; in_rs1 = r1; in_u1 = u1; in_rs2 = r2; in_u2 = u2;
        in_rd = rd; in_wen = wen; in_ld = ld; in_jump = jmp;
        drive();
    endtask

    task automatic model_reset();
        rec_t b;
        b = '{valid: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
        mq.delete();
        for (int i = 0; i < NUM_STAGES; i++) mq.push_back(b);
        mcnt = 0;
        m_stall = 1'b0;
    endtask

    task automatic model_lookup(input bit used, input int src, output bit hit,
                                output bit rdy, output logic [31:0] d);
        hit = 1'b0; rdy = 1'b0; d = '0;
        if (used && src != 0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!hit && mq[i].valid && mq[i].wen && mq[i].rd == src) begin
                    hit = 1'b1;
                    rdy = !mq[i].ld || (i >= LOAD_STAGE);
                    d   = sdata[i];
                end
            end
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic run_cycle(input string tag);
        bit h1, r1, h2, r2, hz, en1, en2;
        logic [31:0] d1, d2;
        rec_t n;
        @(negedge clk);
        model_lookup(in_u1, in_rs1, h1, r1, d1);
        model_lookup(in_u2, in_rs2, h2, r2, d2);
        hz  = FWD ? ((h1 && !r1) || (h2 && !r2)) : (h1 || h2);
        m_stall = hz && !in_jump;
        en1 = FWD && h1 && r1;
        en2 = FWD && h2 && r2;
        chk({tag, " stall"},   32'(bus.stall),      32'(m_stall));
        chk({tag, " flush"},   32'(bus.flush),      32'(in_jump));
        chk({tag, " rs1_en"},  32'(bus.rs1_fwd_en), 32'(en1));
        chk({tag, " rs1_dat"}, bus.rs1_fwd_data,    en1 ? d1 : 32'h0);
        chk({tag, " rs2_en"},  32'(bus.rs2_fwd_en), 32'(en2));
        chk({tag, " rs2_dat"}, bus.rs2_fwd_data,    en2 ? d2 : 32'h0);
        chk({tag, " cnt"},     32'(bus.stall_cnt),  32'(mcnt));
        if (m_stall && mcnt != CNT_MAX) mcnt++;
        n = '{valid: in_valid && !m_stall && !in_jump, rd: in_rd, wen: in_wen, ld: in_ld};
        mq.push_front(n);
        void'(mq.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int guard;
        sdata[0] = 32'h11; sdata[1] = 32'h77; sdata[2] = 32'h22;

        // valid rs1 u1 rs2 u2 rd wen ld jump | stall en1 d1 en2 d2 cnt
        if (FWD) begin
            tv.push_back('{1, 0,0, 0,0,  5,1,0, 0,  0, 0,   0, 0,   0, 0});
            tv.push_back('{1, 5,1, 0,1,  6,1,0, 0,  0, 1,'h11, 0,   0, 0});
            tv.push_back('{1, 0,0, 0,0,  7,1,1, 0,  0, 0,   0, 0,   0, 0});
            tv.push_back('{1, 7,1, 7,1,  8,1,0, 0,  1, 0,   0, 0,   0, 0});
            tv.push_back('{1, 7,1, 7,1,  8,1,0, 0,  0, 1,'h77, 1,'h77, 1});
            tv.push_back('{1, 0,0, 0,0,  5,1,0, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1, 0,0, 0,0,  9,1,0, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1, 0,0, 0,0,  5,1,0, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1, 5,1, 5,1, 10,1,0, 0,  0, 1,'h11, 1,'h11, 1});
            tv.push_back('{1, 0,0, 0,0,  0,1,0, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1, 0,1, 5,1, 11,1,0, 0,  0, 0,   0, 1,'h22, 1});
            tv.push_back('{1, 0,0, 0,0, 12,1,1, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1,12,1, 0,1, 13,1,0, 1,  0, 0,   0, 0,   0, 1});
            tv.push_back('{1,13,1,12,1, 14,1,0, 0,  0, 0,   0, 1,'h77, 1});
            tv.push_back('{0,14,0, 0,0,  0,0,0, 0,  0, 0,   0, 0,   0, 1});
            tv.push_back('{0,14,1, 0,0,  0,0,0, 0,  0, 1,'h77, 0,   0, 1});
        end else begin
            tv.push_back('{1, 0,0, 0,0,  5,1,0, 0,  0, 0,0, 0,0, 0});
            tv.push_back('{1, 5,1, 0,1,  6,1,0, 0,  1, 0,0, 0,0, 0});
            tv.push_back('{1, 5,1, 0,1,  6,1,0, 0,  1, 0,0, 0,0, 1});
            tv.push_back('{1, 5,1, 0,1,  6,1,0, 0,  1, 0,0, 0,0, 2});
            tv.push_back('{1, 5,1, 0,1,  6,1,0, 0,  0, 0,0, 0,0, 3});
            tv.push_back('{1, 0,0, 0,0,  7,1,1, 0,  0, 0,0, 0,0, 3});
            tv.push_back('{1, 7,1, 6,1,  8,1,0, 0,  1, 0,0, 0,0, 3});
            tv.push_back('{1, 7,1, 6,1,  8,1,0, 1,  0, 0,0, 0,0, 4});
            tv.push_back('{0, 0,0, 0,0,  0,0,0, 0,  0, 0,0, 0,0, 4});
            tv.push_back('{1, 8,1, 0,1,  9,1,0, 0,  0, 0,0, 0,0, 4});
            tv.push_back('{0, 9,0, 0,0,  0,0,0, 0,  0, 0,0, 0,0, 4});
            tv.push_back('{1, 0,0, 0,0,  0,1,0, 0,  0, 0,0, 0,0, 4});
            tv.push_back('{1, 0,1, 0,1,  3,1,0, 0,  0, 0,0, 0,0, 4});
            tv.push_back('{1, 9,1, 0,0,  3,1,0, 0,  0, 0,0, 0,0, 4});
        end

        do_reset();
        @(negedge clk);
        chk("reset stall", 32'(bus.stall), 32'h0);
        chk("reset cnt",   32'(bus.stall_cnt), 32'h0);
        chk("reset rs1en", 32'(bus.rs1_fwd_en), 32'h0);
        @(posedge clk); #1;

        // directed vector table
        foreach (tv[i]) begin
            set_instr(tv[i].valid[0], tv[i].rs1, tv[i].u1[0], tv[i].rs2, tv[i].u2[0],
                      tv[i].rd, tv[i].wen[0], tv[i].ld[0], tv[i].jump[0]);
            @(negedge clk);
            chk($sformatf("tbl[%0d] stall", i),   32'(bus.stall),      tv[i].e_stall);
            chk($sformatf("tbl[%0d] flush", i),   32'(bus.flush),      tv[i].jump);
            chk($sformatf("tbl[%0d] rs1_en", i),  32'(bus.rs1_fwd_en), tv[i].e_en1);
            chk($sformatf("tbl[%0d] rs1_dat", i), bus.rs1_fwd_data,    tv[i].e_d1);
            chk($sformatf("tbl[%0d] rs2_en", i),  32'(bus.rs2_fwd_en), tv[i].e_en2);
            chk($sformatf("tbl[%0d] rs2_dat", i), bus.rs2_fwd_data,    tv[i].e_d2);
            chk($sformatf("tbl[%0d] cnt", i),     32'(bus.stall_cnt),  tv[i].e_cnt);
            @(posedge clk); #1;
        end

        // reset asserted in the middle of a load-use stall
        set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0);
        @(posedge clk); #1;
        set_instr(1, 5, 1, 5, 1, 6, 1, 0, 0);
        @(negedge clk);
        chk("pre_rst stall", 32'(bus.stall), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst stall",  32'(bus.stall),        32'h0);
        chk("mid_rst cnt",    32'(bus.stall_cnt),    32'h0);
        chk("mid_rst rs1en",  32'(bus.rs1_fwd_en),   32'h0);
        chk("mid_rst rs1dat", bus.rs1_fwd_data,      32'h0);
        chk("mid_rst flush0", 32'(bus.flush),        32'h0);
        in_jump = 1'b1; drive(); #1;
        chk("mid_rst flush1", 32'(bus.flush),        32'h1);
        in_jump = 1'b0; drive();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        run_cycle("post_rst");

        // counter saturation via repeated load-use pairs
        for (int p = 0; p < 20; p++) begin
            set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0);
            run_cycle("sat_lw");
            set_instr(1, 5, 1, 5, 1, 6, 1, 0, 0);
            guard = 0;
            do begin
                run_cycle("sat_use");
                guard++;
            end while (m_stall && guard < 8);
            if (guard >= 8) chk("sat_use bound", 32'(guard), 32'h0);
        end
        @(negedge clk);
        chk("sat cnt", 32'(bus.stall_cnt), CNT_MAX);
        @(posedge clk); #1;

        // randomized traffic on a small register set for dense hazards
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < NUM_STAGES; k++) sdata[k] = $urandom;
            set_instr(($urandom_range(0, 9) != 0), $urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 9) == 0));
            run_cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
